// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU operation codes, operand/PC select encodings and the FSM state set.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_MEMADR,
    S_MEMRD,
    S_MEM_WB,
    S_MEMWR,
    S_BRANCH,
    S_JUMP
  } state_e;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller (drives
// ALU/mux selects and enables), slave = datapath side (returns IR fields, flags).
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic       mem_ready;
  logic [3:0] ALUCtr;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic [1:0] PCSource;
  logic       pc_en;
  logic       illegal;
  logic       instr_done;

  modport master (
    input  opcode, funct, Zero, mem_ready,
    output ALUCtr, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCSource, pc_en, illegal, instr_done
  );

  modport slave (
    output opcode, funct, Zero, mem_ready,
    input  ALUCtr, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCSource, pc_en, illegal, instr_done
  );
endinterface

// File: rtl/mips_alu_dec.sv
// Combinational ALU-op decode from (state, opcode, funct); zero latency.
// Flags an unsupported R-type funct only while in EXEC_R.
module mips_alu_dec
  import mips_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctr_o,
  output logic       bad_funct_o
);

  logic [3:0] r_ctr;
  logic       r_ok;

  always_comb begin
    r_ctr = ALU_ADD;
    r_ok  = 1'b1;
    case (funct_i)
      FN_ADD:  r_ctr = ALU_ADD;
      FN_SUB:  r_ctr = ALU_SUB;
      FN_AND:  r_ctr = ALU_AND;
      FN_OR:   r_ctr = ALU_OR;
      FN_NOR:  r_ctr = ALU_NOR;
      FN_SLT:  r_ctr = ALU_SLT;
      FN_SLL:  r_ctr = ALU_SLL;
      FN_SRL:  r_ctr = ALU_SRL;
      default: r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctr_o   = ALU_ADD;
    bad_funct_o = 1'b0;
    case (state_i)
      // IDLE is the all-zero reset image, so the op code is 0000 there too
      S_IDLE:   alu_ctr_o = 4'b0000;
      S_EXEC_R: begin
        alu_ctr_o   = r_ctr;
        bad_funct_o = ~r_ok;
      end
      S_EXEC_I: begin
        case (opcode_i)
          OP_ANDI: alu_ctr_o = ALU_AND;
          OP_ORI:  alu_ctr_o = ALU_OR;
          OP_SLTI: alu_ctr_o = ALU_SLT;
          default: alu_ctr_o = ALU_ADD;
        endcase
      end
      S_BRANCH: alu_ctr_o = ALU_SUB;
      default:  alu_ctr_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: 3-5 cycles per instruction plus one per mem_ready=0
// cycle in FETCH/MEMRD/MEMWR; requests and address select are held while waiting.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  mips_mc_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic       alusrca_q;
  logic [1:0] alusrcb_q;
  logic       iord_q;
  logic       memread_q;
  logic       memwrite_q;
  logic       regdst_q;
  logic       memtoreg_q;
  logic       regwrite_q;
  logic [1:0] pcsource_q;
  logic [3:0] alu_ctr;
  logic       bad_funct;
  logic       bad_op;

  mips_alu_dec u_alu_dec (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .funct_i     (bus.funct),
    .alu_ctr_o   (alu_ctr),
    .bad_funct_o (bad_funct)
  );

  assign bad_op = (state_q == S_DECODE) &&
                  !(bus.opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                                       OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J});

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_R:                              state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_EXEC_R: state_d = bad_funct ? S_FETCH : S_R_WB;
      S_EXEC_I: state_d = S_I_WB;
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // State-only outputs are registered from the next state so they line up
  // with state_q; reset clears them to the IDLE image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      alusrca_q  <= 1'b0;
      alusrcb_q  <= SRCB_RT;
      iord_q     <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      regdst_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      pcsource_q <= PCSRC_ALU;
    end else begin
      state_q    <= state_d;
      alusrca_q  <= state_d inside {S_EXEC_R, S_EXEC_I, S_MEMADR, S_BRANCH};
      iord_q     <= state_d inside {S_MEMRD, S_MEMWR};
      memread_q  <= state_d inside {S_FETCH, S_MEMRD};
      memwrite_q <= (state_d == S_MEMWR);
      regdst_q   <= (state_d == S_R_WB);
      memtoreg_q <= (state_d == S_MEM_WB);
      regwrite_q <= state_d inside {S_R_WB, S_I_WB, S_MEM_WB};
      case (state_d)
        S_FETCH:            alusrcb_q <= SRCB_FOUR;
        S_DECODE:           alusrcb_q <= SRCB_IMM_SH2;
        S_EXEC_I, S_MEMADR: alusrcb_q <= SRCB_IMM;
        default:            alusrcb_q <= SRCB_RT;
      endcase
      case (state_d)
        S_BRANCH: pcsource_q <= PCSRC_ALUOUT;
        S_JUMP:   pcsource_q <= PCSRC_JUMP;
        default:  pcsource_q <= PCSRC_ALU;
      endcase
    end
  end

  assign bus.ALUCtr   = alu_ctr;
  assign bus.ALUSrcA  = alusrca_q;
  assign bus.ALUSrcB  = alusrcb_q;
  assign bus.IorD     = iord_q;
  assign bus.MemRead  = memread_q;
  assign bus.MemWrite = memwrite_q;
  assign bus.RegDst   = regdst_q;
  assign bus.MemtoReg = memtoreg_q;
  assign bus.RegWrite = regwrite_q;
  assign bus.PCSource = pcsource_q;

  // Handshake- and flag-qualified strobes must react in the same cycle.
  assign bus.IRWrite    = (state_q == S_FETCH) && bus.mem_ready;
  assign bus.pc_en      = ((state_q == S_FETCH) && bus.mem_ready) ||
                          (state_q == S_JUMP) ||
                          ((state_q == S_BRANCH) && (bus.Zero ^ (bus.opcode == OP_BNE)));
  assign bus.illegal    = bad_op || bad_funct;
  assign bus.instr_done = (state_q inside {S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP}) ||
                          ((state_q == S_MEMWR) && bus.mem_ready);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: directed table, hand-written reset
// corner case, and random instructions against a cycle-position reference model.
module tb_mips_mc_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // [18:15] ALUCtr [14] SrcA [13:12] SrcB [11] IorD [10] MemRead [9] MemWrite
  // [8] IRWrite [7] RegDst [6] MemtoReg [5] RegWrite [4:3] PCSource [2] pc_en
  // [1] illegal [0] instr_done
  logic [18:0] act_vec;
  assign act_vec = {bus.ALUCtr, bus.ALUSrcA, bus.ALUSrcB, bus.IorD, bus.MemRead,
                    bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                    bus.PCSource, bus.pc_en, bus.illegal, bus.instr_done};

  typedef enum int {K_R, K_RBAD, K_I, K_LW, K_SW, K_BR, K_J, K_BAD} kind_e;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         fw;
    int         mw;
    int         zmode;
    int         exp_len;
    logic       exp_ill;
    logic       chk_alu;
    logic [3:0] exp_alu;
    logic [1:0] exp_pcsrc;
    logic       exp_pcen;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return {1'b1, 4'b0010};
      6'h22:   return {1'b1, 4'b0110};
      6'h24:   return {1'b1, 4'b0000};
      6'h25:   return {1'b1, 4'b0001};
      6'h27:   return {1'b1, 4'b1100};
      6'h2A:   return {1'b1, 4'b0111};
      6'h00:   return {1'b1, 4'b0100};
      6'h02:   return {1'b1, 4'b0101};
      default: return 5'b0;
    endcase
  endfunction

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    logic [4:0] r;
    r = r_alu(fn);
    case (op)
      6'h00:                      return r[4] ? K_R : K_RBAD;
      6'h23:                      return K_LW;
      6'h2B:                      return K_SW;
      6'h04, 6'h05:               return K_BR;
      6'h08, 6'h0C, 6'h0D, 6'h0A: return K_I;
      6'h02:                      return K_J;
      default:                    return K_BAD;
    endcase
  endfunction

  // Cycles from first FETCH cycle through the last cycle of the instruction.
  function automatic int ilen(input kind_e k, input int fw, input int mw);
    int nf;
    nf = fw + 1;
    case (k)
      K_BAD:              return nf + 1;
      K_RBAD, K_BR, K_J:  return nf + 2;
      K_R, K_I:           return nf + 3;
      K_SW:               return nf + mw + 3;
      default:            return nf + mw + 4;
    endcase
  endfunction

  function automatic logic mem_sched(input kind_e k, input int fw, input int mw, input int c);
    int ms;
    ms = fw + 3;
    if (c < fw) return 1'b0;
    if (c == fw) return 1'b1;
    if ((k == K_LW || k == K_SW) && c >= ms && c < ms + mw) return 1'b0;
    if ((k == K_LW || k == K_SW) && c == ms + mw) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [18:0] exp_vec(input kind_e k, input logic [5:0] op, input logic [5:0] fn,
                                          input int fw, input int mw, input int c, input logic z);
    int nf, e, len;
    logic last, memc, fin_bad;
    logic [3:0] alu;
    logic [4:0] r;
    logic [1:0] srcb, pcsrc;
    nf = fw + 1;
    e = nf + 1;
    len = ilen(k, fw, mw);
    last = (c == len - 1);
    memc = (k == K_LW || k == K_SW) && c >= nf + 2 && c <= nf + 2 + mw;
    fin_bad = (k == K_BAD || k == K_RBAD);
    r = r_alu(fn);
    alu = 4'b0010;
    if (c == e) begin
      if (k == K_R) alu = r[3:0];
      else if (k == K_BR) alu = 4'b0110;
      else if (k == K_I) alu = (op == 6'h0C) ? 4'b0000 : (op == 6'h0D) ? 4'b0001 :
                               (op == 6'h0A) ? 4'b0111 : 4'b0010;
    end
    if (c <= fw) srcb = 2'b01;
    else if (c == nf) srcb = 2'b11;
    else if (c == e && (k == K_I || k == K_LW || k == K_SW)) srcb = 2'b10;
    else srcb = 2'b00;
    pcsrc = (k == K_BR && last) ? 2'b01 : (k == K_J && last) ? 2'b10 : 2'b00;
    return {alu,
            1'(c == e && k != K_J && k != K_BAD),
            srcb,
            memc,
            1'(c <= fw || (memc && k == K_LW)),
            1'(memc && k == K_SW),
            1'(c == fw),
            1'(k == K_R && last),
            1'(k == K_LW && last),
            1'((k == K_R || k == K_I || k == K_LW) && last),
            pcsrc,
            1'(c == fw || (k == K_J && last) || (k == K_BR && last && ((op == 6'h04) ? z : !z))),
            1'(fin_bad && last),
            1'(!fin_bad && last)};
  endfunction

  // Entered just after a posedge with the DUT in the first FETCH cycle;
  // returns just after the posedge that starts the next instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                           input int zmode, output int m_len, output logic m_ill,
                           output logic [3:0] m_alu, output logic [1:0] m_pcsrc, output logic m_pcen);
    kind_e k;
    int nf, len;
    logic z;
    logic [18:0] ev, mask;
    k = classify(op, fn);
    nf = fw + 1;
    len = ilen(k, fw, mw);
    m_len = 0;
    m_ill = 1'b0;
    m_alu = 4'b0;
    m_pcsrc = 2'b0;
    m_pcen = 1'b0;
    for (int c = 0; c < len; c++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      bus.Zero = z;
      bus.mem_ready = mem_sched(k, fw, mw, c);
      if (c < nf) begin
        bus.opcode = 6'($urandom);
        bus.funct  = 6'($urandom);
      end else begin
        bus.opcode = op;
        bus.funct  = fn;
      end
      @(negedge clk);
      ev = exp_vec(k, op, fn, fw, mw, c, z);
      mask = '1;
      if (k == K_RBAD && c == nf + 1) mask[18:15] = 4'b0;
      check($sformatf("op%02h fn%02h cyc%0d outputs", op, fn, c),
            32'(act_vec & mask), 32'(ev & mask));
      if (c == nf + 1) m_alu = bus.ALUCtr;
      if (m_len == 0 && (bus.illegal || bus.instr_done)) begin
        m_len = c + 1;
        m_ill = bus.illegal;
        m_pcsrc = bus.PCSource;
        m_pcen = bus.pc_en;
      end
      @(posedge clk);
      #1;
    end
  endtask

  vec_t       tbl[14];
  logic [5:0] op_pool[14];
  logic [5:0] fn_pool[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         m_len;
    logic       m_ill, m_pcen;
    logic [3:0] m_alu;
    logic [1:0] m_pcsrc;
    logic [5:0] op, fn;

    //          op     fn     fw mw z  len ill chk alu      pcsrc  pcen
    tbl[0]  = '{6'h23, 6'h00, 2, 1, 0, 8,  0,  1,  4'b0010, 2'b00, 0};
    tbl[1]  = '{6'h00, 6'h22, 0, 0, 0, 4,  0,  1,  4'b0110, 2'b00, 0};
    tbl[2]  = '{6'h00, 6'h27, 0, 0, 0, 4,  0,  1,  4'b1100, 2'b00, 0};
    tbl[3]  = '{6'h04, 6'h00, 0, 0, 1, 3,  0,  1,  4'b0110, 2'b01, 1};
    tbl[4]  = '{6'h05, 6'h00, 0, 0, 1, 3,  0,  1,  4'b0110, 2'b01, 0};
    tbl[5]  = '{6'h3F, 6'h00, 0, 0, 0, 2,  1,  0,  4'b0000, 2'b00, 0};
    tbl[6]  = '{6'h00, 6'h3F, 0, 0, 0, 3,  1,  0,  4'b0000, 2'b00, 0};
    tbl[7]  = '{6'h02, 6'h00, 0, 0, 0, 3,  0,  1,  4'b0010, 2'b10, 1};
    tbl[8]  = '{6'h2B, 6'h00, 1, 2, 0, 7,  0,  1,  4'b0010, 2'b00, 0};
    tbl[9]  = '{6'h0A, 6'h00, 0, 0, 0, 4,  0,  1,  4'b0111, 2'b00, 0};
    tbl[10] = '{6'h0C, 6'h00, 3, 0, 0, 7,  0,  1,  4'b0000, 2'b00, 0};
    tbl[11] = '{6'h00, 6'h00, 0, 0, 0, 4,  0,  1,  4'b0100, 2'b00, 0};
    tbl[12] = '{6'h05, 6'h00, 0, 0, 0, 3,  0,  1,  4'b0110, 2'b01, 1};
    tbl[13] = '{6'h23, 6'h00, 0, 0, 0, 5,  0,  1,  4'b0010, 2'b00, 0};

    op_pool = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08,
                6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h3F, 6'h01, 6'h10};
    fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};

    rst_n = 1'b0;
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b1;
    #3;
    check("reset outputs", 32'(act_vec), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after release", 32'(act_vec), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].fw, tbl[i].mw, tbl[i].zmode,
                m_len, m_ill, m_alu, m_pcsrc, m_pcen);
      check($sformatf("tbl%0d length", i), 32'(m_len), 32'(tbl[i].exp_len));
      check($sformatf("tbl%0d illegal", i), 32'(m_ill), 32'(tbl[i].exp_ill));
      if (tbl[i].chk_alu) check($sformatf("tbl%0d ALUCtr", i), 32'(m_alu), 32'(tbl[i].exp_alu));
      check($sformatf("tbl%0d PCSource", i), 32'(m_pcsrc), 32'(tbl[i].exp_pcsrc));
      check($sformatf("tbl%0d pc_en", i), 32'(m_pcen), 32'(tbl[i].exp_pcen));
    end

    // sw stalled in MEMWR, then reset asserted mid-cycle
    bus.opcode = 6'h2B;
    bus.funct = 6'h00;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("memwr wait outputs", 32'(act_vec), 32'(19'b0010_0_00_1_0_1_0_0_0_0_00_0_0_0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset mid-memwr", 32'(act_vec), 32'd0);
    @(posedge clk);
    #1;
    check("held in reset", 32'(act_vec), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after re-release", 32'(act_vec), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) begin
      op = op_pool[$urandom_range(0, 13)];
      fn = ($urandom_range(0, 9) < 8) ? fn_pool[$urandom_range(0, 7)] : 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 2,
                m_len, m_ill, m_alu, m_pcsrc, m_pcen);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
